hazard_ctrl: RTL
================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 16, the width of each statistics counter.
REQ-002 SHALL have port clock  in  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have ports rs_FD, rt_FD  in  5 each  source registers of the instruction in decode.
REQ-005 SHALL have port useRt_FD  in  1  decode instruction reads rt.
REQ-006 SHALL have ports rs_DX, rt_DX  in  5 each  source registers of the instruction in execute.
REQ-007 SHALL have ports regWriteSel_DX, regWriteSel_XM, regWriteSel_MW  in  5 each  destination register per stage.
REQ-008 SHALL have ports regWrite_DX, regWrite_XM, regWrite_MW  in  1 each  stage writes the register file.
REQ-009 SHALL have port memRead_DX  in  1  execute instruction is a load.
REQ-010 SHALL have port branchTaken  in  1  execute resolved a taken branch or jump.
REQ-011 SHALL have port memBusy  in  1  data memory not ready.
REQ-012 SHALL have ports forwardA, forwardB  out  2 each  execute operand select: 00 register file, 01 EX/MEM ALU result, 10 MEM/WB write-back data, 11 zero (never driven).
REQ-013 SHALL have ports pcWrite, fdWrite, dxWrite, xmWrite, mwWrite  out  1 each  stage register enables.
REQ-014 SHALL have ports flushFD, bubbleDX  out  1 each  clear FD register to NOP / insert NOP into DX.
REQ-015 SHALL have ports stallCycles, flushCount  out  CNT_W each  statistics counters.

Function
REQ-016 SHALL drive forwardA = 01 when regWrite_XM, regWriteSel_XM != 0 and regWriteSel_XM == rs_DX; else 10 when the same holds for MW; else 00. forwardB likewise on rt_DX.
REQ-017 SHALL give EX/MEM priority over MEM/WB; register 0 is never forwarded.
REQ-018 SHALL compute forwarding combinationally in every state, including MEM_WAIT.
REQ-019 SHALL detect load-use when memRead_DX, regWriteSel_DX != 0, and (regWriteSel_DX == rs_FD or (useRt_FD and regWriteSel_DX == rt_FD)).
REQ-020 SHALL implement FSM states RUN, LU_STALL, BR_FLUSH, MEM_WAIT; reset state RUN.
REQ-021 SHALL apply per-cycle priority: memBusy > branchTaken > load-use > none.
REQ-022 SHALL, when memBusy: drive all five enables 0, flushFD 0 and bubbleDX 0; next state MEM_WAIT.
REQ-023 SHALL, when not memBusy and branchTaken: drive flushFD 1 and bubbleDX 1 with all enables 1; next state BR_FLUSH.
REQ-024 SHALL, when not memBusy, not branchTaken, load-use detected, and state not LU_STALL/BR_FLUSH: drive pcWrite 0, fdWrite 0, bubbleDX 1, other enables 1; next state LU_STALL.
REQ-025 SHALL suppress load-use detection in LU_STALL and BR_FLUSH (DX holds a bubble); otherwise drive all enables 1, flushFD 0, bubbleDX 0; next state RUN.
REQ-026 SHALL, in MEM_WAIT with memBusy low, re-evaluate held inputs per REQ-021; a pending load-use or branch is serviced on the first non-busy cycle and not lost.
REQ-027 SHALL cap any load-use stall at exactly one cycle.
REQ-028 SHALL increment stallCycles each cycle pcWrite is 0, saturating at all-ones.
REQ-029 SHALL increment flushCount once per cycle flushFD is 1, saturating at all-ones.
REQ-030 SHALL have outputs as a Mealy function of state and current inputs, with zero-cycle latency.

Reset
REQ-031 SHALL, while reset is high: state RUN, counters 0, enables 1, flushFD 0, bubbleDX 0, forwardA/forwardB 00.
REQ-032 SHALL, on reset asserted mid-stall or mid-wait, abandon the event; the first cycle after reset deassertion is RUN.

Structure
REQ-033 SHALL place forward-select encodings (00/01/10/11) and FSM state encodings in the shared pipeline package, used also by the execute stage.
REQ-034 SHALL instantiate one sub-module, fwd_sel, which computes a single 2-bit forward code and is instantiated twice (rs, rt).

Verification
REQ-035 SHALL cover: XM dest 5 regWrite, MW dest 5 regWrite, rs_DX 5 -> forwardA 01; drop XM regWrite -> 10; dest 0 -> 00.
REQ-036 SHALL cover: memRead_DX, regWriteSel_DX 3, rt_FD 3, useRt_FD 1 -> one cycle pcWrite 0, fdWrite 0, bubbleDX 1, stallCycles 1; next cycle all enables 1.
REQ-037 SHALL cover: branchTaken with load-use same cycle -> flushFD 1, bubbleDX 1, pcWrite 1, flushCount 1, no stall.
REQ-038 SHALL cover: memBusy 3 cycles during load-use -> enables 0 for 3 cycles, then 1-cycle load-use stall; stallCycles 4.
REQ-039 SHALL cover: stallCycles preloaded to 16'hFFFF by repeated stalls -> holds 16'hFFFF.
REQ-040 SHALL cover: reset during MEM_WAIT -> next cycle RUN, counters 0, all enables 1.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline package: forward-select codes, hazard FSM states and the
// stage-enable bundle. The execute stage decodes the same fwd_e values on
// its operand muxes.
package hazard_ctrl_pkg;

  localparam int REG_W = 5;

  // Execute operand source select
  typedef enum logic [1:0] {
    FWD_RF   = 2'b00,  // register file read data
    FWD_XM   = 2'b01,  // EX/MEM ALU result
    FWD_MW   = 2'b10,  // MEM/WB write-back data
    FWD_ZERO = 2'b11   // constant zero, never selected by hazard_ctrl
  } fwd_e;

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_LU_STALL = 2'b01,
    ST_BR_FLUSH = 2'b10,
    ST_MEM_WAIT = 2'b11
  } hz_state_e;

  // Pipeline register write enables, PC first
  typedef struct packed {
    logic pc;
    logic fd;
    logic dx;
    logic xm;
    logic mw;
  } stage_en_t;

endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// fwd_sel: forward code for one execute source operand.
//   src            : source register read by the execute instruction
//   wr_xm, sel_xm  : EX/MEM writes the register file, and its destination
//   wr_mw, sel_mw  : MEM/WB writes the register file, and its destination
//   code           : FWD_XM / FWD_MW / FWD_RF
// EX/MEM wins because it holds the younger value; r0 is hardwired zero and
// is never forwarded.
module fwd_sel
  import hazard_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] src,
  input  logic             wr_xm,
  input  logic [REG_W-1:0] sel_xm,
  input  logic             wr_mw,
  input  logic [REG_W-1:0] sel_mw,
  output fwd_e             code
);

  always_comb begin
    code = FWD_RF;
    if (wr_xm && (sel_xm != '0) && (sel_xm == src))
      code = FWD_XM;
    else if (wr_mw && (sel_mw != '0) && (sel_mw == src))
      code = FWD_MW;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: forwarding selects, stall/flush control and statistics for a
// 5-stage pipeline.
//   clock, reset                 : single clock, synchronous active-high reset
//   rs_FD, rt_FD, useRt_FD       : decode-stage sources
//   rs_DX, rt_DX                 : execute-stage sources
//   regWriteSel_*, regWrite_*    : destination / write flag per stage
//   memRead_DX                   : execute instruction is a load
//   branchTaken                  : execute resolved a taken branch/jump
//   memBusy                      : data memory not ready, freeze everything
//   forwardA, forwardB           : execute operand selects (fwd_e)
//   pcWrite..mwWrite             : stage register enables
//   flushFD, bubbleDX            : squash FD / inject NOP into DX
//   stallCycles, flushCount      : saturating statistics counters
// All control outputs are Mealy: state plus the current cycle's inputs.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [REG_W-1:0] rs_FD,
  input  logic [REG_W-1:0] rt_FD,
  input  logic             useRt_FD,
  input  logic [REG_W-1:0] rs_DX,
  input  logic [REG_W-1:0] rt_DX,
  input  logic [REG_W-1:0] regWriteSel_DX,
  input  logic [REG_W-1:0] regWriteSel_XM,
  input  logic [REG_W-1:0] regWriteSel_MW,
  input  logic             regWrite_DX,
  input  logic             regWrite_XM,
  input  logic             regWrite_MW,
  input  logic             memRead_DX,
  input  logic             branchTaken,
  input  logic             memBusy,
  output logic [1:0]       forwardA,
  output logic [1:0]       forwardB,
  output logic             pcWrite,
  output logic             fdWrite,
  output logic             dxWrite,
  output logic             xmWrite,
  output logic             mwWrite,
  output logic             flushFD,
  output logic             bubbleDX,
  output logic [CNT_W-1:0] stallCycles,
  output logic [CNT_W-1:0] flushCount
);

  hz_state_e  state, state_n;
  stage_en_t  en;
  fwd_e       fwd_a, fwd_b;
  logic       lu_raw, lu_hit;
  logic [CNT_W-1:0] stall_q, flush_q;

  // Loads always write a destination, so the DX write flag adds nothing to
  // load-use detection; it stays on the port list for interface symmetry.
  logic unused_rw_dx;
  assign unused_rw_dx = regWrite_DX;

  fwd_sel u_fwd_a (
    .src(rs_DX), .wr_xm(regWrite_XM), .sel_xm(regWriteSel_XM),
    .wr_mw(regWrite_MW), .sel_mw(regWriteSel_MW), .code(fwd_a)
  );

  fwd_sel u_fwd_b (
    .src(rt_DX), .wr_xm(regWrite_XM), .sel_xm(regWriteSel_XM),
    .wr_mw(regWrite_MW), .sel_mw(regWriteSel_MW), .code(fwd_b)
  );

  assign forwardA = reset ? FWD_RF : fwd_a;
  assign forwardB = reset ? FWD_RF : fwd_b;

  assign lu_raw = memRead_DX && (regWriteSel_DX != '0) &&
                  ((regWriteSel_DX == rs_FD) ||
                   (useRt_FD && (regWriteSel_DX == rt_FD)));
  // After a stall or flush DX holds a bubble, so any match is stale; this
  // also bounds a load-use stall to one cycle. MEM_WAIT does not suppress,
  // so a held load-use is serviced once memory frees up.
  assign lu_hit = lu_raw && (state != ST_LU_STALL) && (state != ST_BR_FLUSH);

  // State register
  always_ff @(posedge clock) begin
    if (reset) state <= ST_RUN;
    else       state <= state_n;
  end

  // Next state
  always_comb begin
    state_n = ST_RUN;
    if (memBusy)          state_n = ST_MEM_WAIT;
    else if (branchTaken) state_n = ST_BR_FLUSH;
    else if (lu_hit)      state_n = ST_LU_STALL;
  end

  // Outputs
  always_comb begin
    en       = '1;
    flushFD  = 1'b0;
    bubbleDX = 1'b0;
    if (!reset) begin
      if (memBusy) begin
        en = '0;
      end else if (branchTaken) begin
        flushFD  = 1'b1;
        bubbleDX = 1'b1;
      end else if (lu_hit) begin
        en.pc    = 1'b0;
        en.fd    = 1'b0;
        bubbleDX = 1'b1;
      end
    end
  end

  assign pcWrite = en.pc;
  assign fdWrite = en.fd;
  assign dxWrite = en.dx;
  assign xmWrite = en.xm;
  assign mwWrite = en.mw;

  always_ff @(posedge clock) begin
    if (reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!en.pc && (stall_q != '1)) stall_q <= stall_q + 1'b1;
      if (flushFD && (flush_q != '1)) flush_q <= flush_q + 1'b1;
    end
  end

  // Registered counters lag reset by a cycle; mask so they read zero while
  // reset is held.
  assign stallCycles = reset ? '0 : stall_q;
  assign flushCount  = reset ? '0 : flush_q;

endmodule
